arbitro_mem_dados: RTL



---
 rtl/arbitro_mem_dados.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/arbitro_mem_dados.sv
// arbitro_mem_dados
// Two-port request/acknowledge arbiter and sequencer in front of the
// 64x32-bit halfword-access data memory. Port A serves the load/store stage
// and port B serves the I/O/program-loader path. One requester is granted at
// a time. The access is sequenced as LIVRE -> ACESSO -> RESPOSTA. Illegal
// addresses are rejected before they reach the memory.
//
// Ports:
//   clock, reset            rising-edge clock; synchronous active-high reset
//   req_x, esc_x            request (held until ack) and write(1)/read(0)
//   end_x, dado_x           byte address and write data (memory keeps [15:0])
//   ack_x, erro_x           one-cycle completion pulse and reject flag
//   leitura_x               read result, held until that port's next ack
//   mem_endereco, mem_valor address / write data towards the memory
//   mem_escrita, mem_leitura memory strobes (only ever high in ACESSO)
//   mem_dado                combinational sign-extended halfword from memory
//   ocupado                 high whenever the sequencer is not idle
module arbitro_mem_dados #(
  parameter bit          PRIORIDADE_FIXA = 1'b0,
  parameter int unsigned LIMITE_ESPERA   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic        esc_a,
  input  logic [31:0] end_a,
  input  logic [31:0] dado_a,
  input  logic        req_b,
  input  logic        esc_b,
  input  logic [31:0] end_b,
  input  logic [31:0] dado_b,
  output logic        ack_a,
  output logic        erro_a,
  output logic [31:0] leitura_a,
  output logic        ack_b,
  output logic        erro_b,
  output logic [31:0] leitura_b,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_valor,
  output logic        mem_escrita,
  output logic        mem_leitura,
  input  logic [31:0] mem_dado,
  output logic        ocupado
);

  typedef enum logic [1:0] {
    LIVRE,
    ACESSO,
    RESPOSTA
  } estado_t;

  localparam logic [3:0] LIMITE = 4'(LIMITE_ESPERA);

  estado_t     estado;
  estado_t     proximo;

  logic        dono_b;     // 1 = port B owns the current transaction
  logic        ultimo_b;   // 1 = port B was granted last
  logic [3:0]  espera_b;   // consecutive contention losses of B
  logic        esc_reg;
  logic [31:0] end_reg;
  logic [31:0] dado_reg;
  logic        falha;

  logic        vence_b;
  logic        esc_sel;
  logic [31:0] end_sel;
  logic [31:0] dado_sel;
  logic        erro_sel;

  // Winner selection for a grant taken in LIVRE.
  always_comb begin
    vence_b = 1'b0;
    if (req_b && !req_a) begin
      vence_b = 1'b1;
    end else if (req_a && req_b) begin
      if (PRIORIDADE_FIXA) begin
        vence_b = (espera_b == LIMITE);
      end else begin
        vence_b = !ultimo_b;
      end
    end
  end

  always_comb begin
    esc_sel  = vence_b ? esc_b  : esc_a;
    end_sel  = vence_b ? end_b  : end_a;
    dado_sel = vence_b ? dado_b : dado_a;
    // Misaligned halfword or outside the 256-byte window.
    erro_sel = end_sel[0] | (|end_sel[31:8]);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= LIVRE;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic.
  always_comb begin
    proximo = estado;
    case (estado)
      LIVRE:    if (req_a || req_b) proximo = ACESSO;
      ACESSO:   proximo = RESPOSTA;
      RESPOSTA: proximo = LIVRE;
      default:  proximo = LIVRE;
    endcase
  end

  // Grant latch, starvation counter and read-result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      dono_b    <= 1'b0;
      ultimo_b  <= 1'b1;
      espera_b  <= '0;
      esc_reg   <= 1'b0;
      end_reg   <= '0;
      dado_reg  <= '0;
      falha     <= 1'b0;
      leitura_a <= '0;
      leitura_b <= '0;
    end else begin
      if (estado == LIVRE && (req_a || req_b)) begin
        dono_b   <= vence_b;
        ultimo_b <= vence_b;
        esc_reg  <= esc_sel;
        end_reg  <= end_sel;
        dado_reg <= dado_sel;
        falha    <= erro_sel;
        if (vence_b) begin
          espera_b <= '0;
        end else if (PRIORIDADE_FIXA && req_b) begin
          espera_b <= espera_b + 4'd1;
        end
      end

      // A rejected access returns 0 even when it was a write.
      if (estado == ACESSO) begin
        if (falha) begin
          if (dono_b) leitura_b <= '0;
          else        leitura_a <= '0;
        end else if (!esc_reg) begin
          if (dono_b) leitura_b <= mem_dado;
          else        leitura_a <= mem_dado;
        end
      end
    end
  end

  // Outputs decoded from the state register and the latched request.
  always_comb begin
    ocupado      = (estado != LIVRE);
    mem_endereco = '0;
    mem_valor    = '0;
    mem_escrita  = 1'b0;
    mem_leitura  = 1'b0;
    ack_a        = 1'b0;
    ack_b        = 1'b0;
    erro_a       = 1'b0;
    erro_b       = 1'b0;
    case (estado)
      ACESSO: begin
        mem_endereco = end_reg;
        mem_valor    = dado_reg;
        mem_escrita  = !falha && esc_reg;
        mem_leitura  = !falha && !esc_reg;
      end
      RESPOSTA: begin
        ack_a  = !dono_b;
        ack_b  = dono_b;
        erro_a = !dono_b && falha;
        erro_b = dono_b && falha;
      end
      default: ;
    endcase
  end

endmodule
